ibex_custom_issue: RTL and testbench



---
 rtl/ibex_custom_issue.sv | 140 ++++++++++++++
 tb/tb_ibex_custom_issue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_custom_issue.sv
// Issue sequencer for the custom-0 bloom-filter ops: decodes in ID, latches operands,
// strobes the EX unit once, stalls ID until EX answers or the wait budget runs out.
module ibex_custom_issue #(
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic [31:0] rs1_rdata_i,
   input  logic [31:0] rs2_rdata_i,
   input  logic        flush_i,
   input  logic        ex_custom_valid_i,
   output logic        custom_en_o,
   output logic        check_bloom_o,
   output logic        match_bloom_o,
   output logic        reset_bloom_o,
   output logic [4:0]  custom_op_o,
   output logic [31:0] custom_rs1_o,
   output logic [31:0] custom_rs2_o,
   output logic        stall_id_o,
   output logic        custom_done_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic        illegal_custom_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

   state_e      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        timeout_flag_reg, timeout_flag_next;
   logic [4:0]  op_reg, rd_reg;
   logic [1:0]  funct3_reg;
   logic [31:0] rs1_reg, rs2_reg;

   logic        is_custom, is_legal, accept;
   logic [2:0]  funct3;
   logic [3:0]  strobe;
   logic        unused_instr_bits;

   assign funct3    = instr_rdata_i[14:12];
   assign is_custom = (instr_rdata_i[6:0] == 7'b0001011);
   assign is_legal  = ~funct3[2];
   // Nothing is accepted while reset is asserted so all outputs read 0 during reset.
   assign accept    = rst_ni & (state_reg == IDLE) & instr_valid_i & is_custom & is_legal & ~flush_i;
   assign illegal_custom_o = rst_ni & (state_reg == IDLE) & instr_valid_i & is_custom & funct3[2] & ~flush_i;
   assign unused_instr_bits = ^instr_rdata_i[26:15];

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      timeout_flag_next = timeout_flag_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next          = 8'd0;
            timeout_flag_next = 1'b0;
            state_next        = WAIT;
         end
         WAIT: begin
            cnt_next = cnt_reg + 8'd1;
            // A response arriving on the last budgeted cycle still counts as a real completion.
            if (ex_custom_valid_i) begin
               state_next        = DONE;
               timeout_flag_next = 1'b0;
            end else if (cnt_reg == CntLast) begin
               state_next        = DONE;
               timeout_flag_next = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (flush_i) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg        <= IDLE;
         cnt_reg          <= 8'd0;
         timeout_flag_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         timeout_flag_reg <= timeout_flag_next;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         op_reg     <= 5'd0;
         rd_reg     <= 5'd0;
         funct3_reg <= 2'd0;
         rs1_reg    <= 32'd0;
         rs2_reg    <= 32'd0;
      end else if (accept) begin
         op_reg     <= instr_rdata_i[31:27];
         rd_reg     <= instr_rdata_i[11:7];
         funct3_reg <= funct3[1:0];
         rs1_reg    <= rs1_rdata_i;
         rs2_reg    <= rs2_rdata_i;
      end
   end

   // One strobe per legal funct3 encoding, bit index equals funct3.
   for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
      assign strobe[gi] = (state_reg == ISSUE) & (funct3_reg == 2'(gi)) & ~flush_i;
   end

   assign custom_en_o   = strobe[0];
   assign check_bloom_o = strobe[1];
   assign match_bloom_o = strobe[2];
   assign reset_bloom_o = strobe[3];

   assign custom_op_o  = op_reg;
   assign custom_rs1_o = rs1_reg;
   assign custom_rs2_o = rs2_reg;
   assign rf_waddr_o   = rd_reg;

   assign stall_id_o    = accept | (state_reg == ISSUE) | (state_reg == WAIT);
   assign custom_done_o = (state_reg == DONE) & ~flush_i;
   assign timeout_o     = custom_done_o & timeout_flag_reg;
   assign rf_we_o       = custom_done_o & ~timeout_flag_reg & (rd_reg != 5'd0)
                        & ((funct3_reg == 2'd1) | (funct3_reg == 2'd2));

endmodule

// File: tb/tb_ibex_custom_issue.sv
// Bench for ibex_custom_issue: table of custom ops with a retire scoreboard,
// plus hand sequences for reset, illegal decode and flush corners.
module tb_ibex_custom_issue;

   localparam int unsigned TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_valid_i;
   logic [31:0] instr_rdata_i;
   logic [31:0] rs1_rdata_i;
   logic [31:0] rs2_rdata_i;
   logic        flush_i;
   logic        ex_custom_valid_i;
   logic        custom_en_o, check_bloom_o, match_bloom_o, reset_bloom_o;
   logic [4:0]  custom_op_o;
   logic [31:0] custom_rs1_o, custom_rs2_o;
   logic        stall_id_o, custom_done_o, rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic        illegal_custom_o, timeout_o;
   logic [3:0]  strb;

   always #5 clk_i = ~clk_i;

   ibex_custom_issue #(.TimeoutCycles(TO)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .instr_valid_i    (instr_valid_i),
      .instr_rdata_i    (instr_rdata_i),
      .rs1_rdata_i      (rs1_rdata_i),
      .rs2_rdata_i      (rs2_rdata_i),
      .flush_i          (flush_i),
      .ex_custom_valid_i(ex_custom_valid_i),
      .custom_en_o      (custom_en_o),
      .check_bloom_o    (check_bloom_o),
      .match_bloom_o    (match_bloom_o),
      .reset_bloom_o    (reset_bloom_o),
      .custom_op_o      (custom_op_o),
      .custom_rs1_o     (custom_rs1_o),
      .custom_rs2_o     (custom_rs2_o),
      .stall_id_o       (stall_id_o),
      .custom_done_o    (custom_done_o),
      .rf_we_o          (rf_we_o),
      .rf_waddr_o       (rf_waddr_o),
      .illegal_custom_o (illegal_custom_o),
      .timeout_o        (timeout_o)
   );

   assign strb = {reset_bloom_o, match_bloom_o, check_bloom_o, custom_en_o};

   typedef struct {
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [4:0]  op;
      logic [31:0] rs1;
      logic [31:0] rs2;
      int          valid_at;   // WAIT cycle index carrying ex valid, -1 = never
      logic        exp_we;
      logic        exp_to;
      int          exp_lat;    // cycles from accept to the done cycle
      logic [3:0]  exp_strb;
   } vec_t;

   typedef struct {
      logic       we;
      logic [4:0] waddr;
      logic       to;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[9];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [2:0] f3,
                                            input logic [4:0] rd);
      return {op, 12'h5A3, f3, rd, 7'b0001011};
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_strobes"}, {28'd0, strb}, 32'd0);
      chk({tag, "_op"}, {27'd0, custom_op_o}, 32'd0);
      chk({tag, "_rs1"}, custom_rs1_o, 32'd0);
      chk({tag, "_rs2"}, custom_rs2_o, 32'd0);
      chk({tag, "_stall"}, {31'd0, stall_id_o}, 32'd0);
      chk({tag, "_done"}, {31'd0, custom_done_o}, 32'd0);
      chk({tag, "_we"}, {31'd0, rf_we_o}, 32'd0);
      chk({tag, "_waddr"}, {27'd0, rf_waddr_o}, 32'd0);
      chk({tag, "_illegal"}, {31'd0, illegal_custom_o}, 32'd0);
      chk({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
   endtask

   task automatic run_op(input vec_t v, input int idx);
      exp_t       e, got;
      bit         done;
      int         strobes;
      int         lat_seen;
      logic [3:0] seen;
      cyc();
      instr_valid_i     = 1'b1;
      instr_rdata_i     = mk_instr(v.op, v.funct3, v.rd);
      rs1_rdata_i       = v.rs1;
      rs2_rdata_i       = v.rs2;
      ex_custom_valid_i = 1'b0;
      e.we = v.exp_we; e.waddr = v.rd; e.to = v.exp_to; e.lat = v.exp_lat;
      sb_q.push_back(e);
      @(negedge clk_i);
      chk("accept_stall", {31'd0, stall_id_o}, 32'd1);
      chk("accept_strobe", {28'd0, strb}, 32'd0);
      done = 1'b0; strobes = 0; seen = 4'd0; lat_seen = 0;
      for (int c = 1; c <= 12 && !done; c++) begin
         cyc();
         instr_valid_i     = 1'b0;
         instr_rdata_i     = 32'd0;
         rs1_rdata_i       = ~v.rs1;
         rs2_rdata_i       = ~v.rs2;
         ex_custom_valid_i = (v.valid_at >= 0) && (c == v.valid_at + 2);
         @(negedge clk_i);
         if (strb != 4'd0) begin
            strobes++;
            seen = seen | strb;
         end
         chk("op_hold", {27'd0, custom_op_o}, {27'd0, v.op});
         chk("rs1_hold", custom_rs1_o, v.rs1);
         chk("rs2_hold", custom_rs2_o, v.rs2);
         if (custom_done_o) begin
            done = 1'b1;
            lat_seen = c;
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
               got = sb_q.pop_front();
               chk("rf_we", {31'd0, rf_we_o}, {31'd0, got.we});
               chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, got.waddr});
               chk("timeout", {31'd0, timeout_o}, {31'd0, got.to});
               chk("latency", c, got.lat);
               chk("done_stall", {31'd0, stall_id_o}, 32'd0);
            end
         end else begin
            chk("busy_stall", {31'd0, stall_id_o}, 32'd1);
         end
      end
      ex_custom_valid_i = 1'b0;
      chk("done_seen", {31'd0, done}, 32'd1);
      if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
      chk("strobe_count", strobes, 1);
      chk("strobe_sel", {28'd0, seen}, {28'd0, v.exp_strb});
      $display("op %0d: funct3=%0d rd=%0d done=%0d after %0d cycles we=%0d timeout=%0d",
               idx, v.funct3, v.rd, done, lat_seen, rf_we_o, timeout_o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      //         f3    rd     op     rs1           rs2           vat we    to    lat strb
      vecs[0] = '{3'd1, 5'd5,  5'h11, 32'hDEADBEEF, 32'h0BADF00D, 1,  1'b1, 1'b0, 4, 4'b0010};
      vecs[1] = '{3'd0, 5'd0,  5'h02, 32'h00000001, 32'h00000002, 0,  1'b0, 1'b0, 3, 4'b0001};
      vecs[2] = '{3'd2, 5'd9,  5'h1F, 32'hA5A5A5A5, 32'h5A5A5A5A, -1, 1'b0, 1'b1, 6, 4'b0100};
      vecs[3] = '{3'd2, 5'd9,  5'h1E, 32'h13579BDF, 32'h2468ACE0, 3,  1'b1, 1'b0, 6, 4'b0100};
      vecs[4] = '{3'd3, 5'd7,  5'h08, 32'hFFFFFFFF, 32'h00000000, 0,  1'b0, 1'b0, 3, 4'b1000};
      vecs[5] = '{3'd0, 5'd3,  5'h04, 32'h80000000, 32'h7FFFFFFF, 2,  1'b0, 1'b0, 5, 4'b0001};
      vecs[6] = '{3'd1, 5'd0,  5'h10, 32'h0F0F0F0F, 32'hF0F0F0F0, 1,  1'b0, 1'b0, 4, 4'b0010};
      vecs[7] = '{3'd2, 5'd31, 5'h15, 32'h12121212, 32'h34343434, 0,  1'b1, 1'b0, 3, 4'b0100};
      vecs[8] = '{3'd1, 5'd12, 5'h0C, 32'hCAFEBABE, 32'hFEEDFACE, -1, 1'b0, 1'b1, 6, 4'b0010};

      rst_ni = 1'b0; instr_valid_i = 1'b0; instr_rdata_i = 32'd0;
      rs1_rdata_i = 32'd0; rs2_rdata_i = 32'd0; flush_i = 1'b0; ex_custom_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_zero("por");
      rst_ni = 1'b1;

      // Reset held low for two edges while waiting on EX.
      cyc();
      instr_valid_i = 1'b1; instr_rdata_i = mk_instr(5'h09, 3'd2, 5'd6);
      rs1_rdata_i = 32'h11112222; rs2_rdata_i = 32'h33334444;
      cyc();
      instr_valid_i = 1'b0;
      cyc();
      @(negedge clk_i);
      chk("pre_reset_stall", {31'd0, stall_id_o}, 32'd1);
      cyc();
      rst_ni = 1'b0;
      cyc();
      @(negedge clk_i);
      check_zero("rst1");
      cyc();
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_zero("rst2");
      for (int i = 0; i < 6; i++) begin
         cyc();
         @(negedge clk_i);
         chk("rst_no_done", {31'd0, custom_done_o}, 32'd0);
      end
      $display("reset during WAIT sequence complete");

      // Reserved funct3 is flagged for one cycle without stalling.
      cyc();
      instr_valid_i = 1'b1; instr_rdata_i = mk_instr(5'h03, 3'b101, 5'd6);
      @(negedge clk_i);
      chk("illegal_flag", {31'd0, illegal_custom_o}, 32'd1);
      chk("illegal_stall", {31'd0, stall_id_o}, 32'd0);
      cyc();
      instr_rdata_i = mk_instr(5'h03, 3'b111, 5'd6); flush_i = 1'b1;
      @(negedge clk_i);
      chk("illegal_strobe", {28'd0, strb}, 32'd0);
      chk("illegal_flushed", {31'd0, illegal_custom_o}, 32'd0);
      cyc();
      instr_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);
      chk("illegal_after_strobe", {28'd0, strb}, 32'd0);
      chk("illegal_after_stall", {31'd0, stall_id_o}, 32'd0);
      $display("illegal funct3 sequence complete");

      // Flush in the ISSUE cycle of a reset op suppresses the strobe.
      cyc();
      instr_valid_i = 1'b1; instr_rdata_i = mk_instr(5'h07, 3'd3, 5'd2);
      rs1_rdata_i = 32'h12345678; rs2_rdata_i = 32'h9ABCDEF0;
      cyc();
      instr_valid_i = 1'b0; flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_issue_reset_bloom", {31'd0, reset_bloom_o}, 32'd0);
      cyc();
      flush_i = 1'b0; ex_custom_valid_i = 1'b1;
      @(negedge clk_i);
      chk("flush_issue_idle", {31'd0, stall_id_o}, 32'd0);
      chk("flush_issue_strobe", {28'd0, strb}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         ex_custom_valid_i = 1'b0;
         @(negedge clk_i);
         chk("flush_issue_no_done", {31'd0, custom_done_o}, 32'd0);
      end
      $display("flush in ISSUE sequence complete");

      // Flush coincident with accept: nothing is latched.
      cyc();
      instr_valid_i = 1'b1; instr_rdata_i = mk_instr(5'h1A, 3'd1, 5'd8);
      rs1_rdata_i = 32'hCAFEF00D; flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_accept_stall", {31'd0, stall_id_o}, 32'd0);
      cyc();
      instr_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_accept_strobe", {28'd0, strb}, 32'd0);
      chk("flush_accept_stall2", {31'd0, stall_id_o}, 32'd0);
      chk("flush_accept_rs1", custom_rs1_o, 32'h12345678);
      $display("flush with accept sequence complete");

      // Flush in the DONE cycle gates retire outputs.
      cyc();
      instr_valid_i = 1'b1; instr_rdata_i = mk_instr(5'h05, 3'd1, 5'd4);
      rs1_rdata_i = 32'h0000BEEF;
      cyc();
      instr_valid_i = 1'b0;
      cyc();
      ex_custom_valid_i = 1'b1;
      cyc();
      ex_custom_valid_i = 1'b0; flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_done_done", {31'd0, custom_done_o}, 32'd0);
      chk("flush_done_we", {31'd0, rf_we_o}, 32'd0);
      cyc();
      flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_done_after", {31'd0, custom_done_o}, 32'd0);
      chk("flush_done_stall", {31'd0, stall_id_o}, 32'd0);
      $display("flush in DONE sequence complete");

      // Flush in WAIT; a late ex valid must not retire anything.
      cyc();
      instr_valid_i = 1'b1; instr_rdata_i = mk_instr(5'h06, 3'd2, 5'd10);
      cyc();
      instr_valid_i = 1'b0;
      cyc();
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0; ex_custom_valid_i = 1'b1;
      @(negedge clk_i);
      chk("flush_wait_idle", {31'd0, stall_id_o}, 32'd0);
      cyc();
      ex_custom_valid_i = 1'b0;
      @(negedge clk_i);
      chk("flush_wait_no_done", {31'd0, custom_done_o}, 32'd0);
      $display("flush in WAIT sequence complete");

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i], i);
      end

      chk("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
